// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding architectural HI/LO for the EX stage.
// Optional MADD/MADDU/MSUB/MSUBU (ops 7-10) are enabled by defining MDU_MADD_EN.
module mult_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        state_dbg
);
    // Handshake: an op is taken only when start=1 and busy=0; start during busy is dropped.
    localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   hi_q, lo_q, phi_q, plo_q;
    logic          div0_q;

    logic [63:0] prod_s, prod_u, res_d;
    logic [31:0] a_mag, b_mag, mag_q, mag_r, quo_s, rem_s, quo_u, rem_u;
    logic        b_zero, launch_mul, launch_div, wr_hi, wr_lo;
`ifdef MDU_MADD_EN
    logic [63:0] acc;
    assign acc = {hi_q, lo_q};
`endif

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign b_zero = (b == 32'd0);
    assign a_mag  = a[31] ? (~a + 32'd1) : a;
    assign b_mag  = b[31] ? (~b + 32'd1) : b;
    assign mag_q  = b_zero ? 32'd0 : a_mag / b_mag;
    assign mag_r  = b_zero ? 32'd0 : a_mag % b_mag;
    assign quo_s  = (a[31] ^ b[31]) ? (~mag_q + 32'd1) : mag_q;
    assign rem_s  = a[31] ? (~mag_r + 32'd1) : mag_r;
    assign quo_u  = b_zero ? 32'd0 : a / b;
    assign rem_u  = b_zero ? 32'd0 : a % b;

    always_comb begin
        res_d      = 64'd0;
        launch_mul = 1'b0;
        launch_div = 1'b0;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;
        case (op)
            OP_MULT:  begin launch_mul = 1'b1; res_d = prod_s; end
            OP_MULTU: begin launch_mul = 1'b1; res_d = prod_u; end
            OP_DIV:   begin launch_div = 1'b1; res_d = {rem_s, quo_s}; end
            OP_DIVU:  begin launch_div = 1'b1; res_d = {rem_u, quo_u}; end
            OP_MTHI:  wr_hi = 1'b1;
            OP_MTLO:  wr_lo = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD:  begin launch_mul = 1'b1; res_d = acc + prod_s; end
            OP_MADDU: begin launch_mul = 1'b1; res_d = acc + prod_u; end
            OP_MSUB:  begin launch_mul = 1'b1; res_d = acc - prod_s; end
            OP_MSUBU: begin launch_mul = 1'b1; res_d = acc - prod_u; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
            div0_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (launch_mul || launch_div) begin
                            state_q        <= RUN;
                            cnt_q          <= launch_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                            {phi_q, plo_q} <= res_d;
                            div0_q         <= launch_div && b_zero;
                        end
                        if (wr_hi) hi_q <= a;
                        if (wr_lo) lo_q <= a;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= IDLE;
                        if (!div0_q) begin
                            hi_q <= phi_q;
                            lo_q <= plo_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (cnt_q != '0);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign state_dbg = (state_q == RUN);
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (default MUL_CYCLES=5, DIV_CYCLES=10).
module tb_mult_div_unit;
  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Entered and left at a negedge. Issues one op, counts busy cycles (bounded),
  // checks HI/LO stay old during RUN and take the expected values afterwards.
  task automatic run_op(input string tag, input logic [3:0] op_v, input logic [31:0] av,
                        input logic [31:0] bv, input int n_exp,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int c;
    start = 1'b1; op = op_v; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    c = 0;
    while (busy === 1'b1 && c < 40) begin
      if (c == 0) begin
        check({tag, "_hold_hi"}, hi, m_hi);
        check({tag, "_hold_lo"}, lo, m_lo);
      end
      c++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(c), 32'(n_exp));
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  initial begin
    int c;
    reset = 1'b1; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    // reset and start on the same edge: reset wins
    start = 1'b1; op = 4'd5; a = 32'h0000_0055;
    @(negedge clk);
    reset = 1'b0; start = 1'b0; op = 4'd0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    run_op("mult",  4'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div",   4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu0", 4'd4, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

    // MTHI then MTLO on consecutive edges
    start = 1'b1; op = 4'd5; a = 32'h1234_5678;
    @(negedge clk);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_lo", lo, 32'h8000_0000);
    check("mthi_busy", 32'(busy), 32'd0);
    op = 4'd6; a = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    check("mtlo_lo", lo, 32'h9ABC_DEF0);
    check("mtlo_hi", hi, 32'h1234_5678);
    check("mtlo_busy", 32'(busy), 32'd0);
    m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;

    // MULT issued during RUN is ignored
    start = 1'b1; op = 4'd1; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    c = 0;
    if (busy === 1'b1) c++;
    start = 1'b1; op = 4'd1; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    while (busy === 1'b1 && c < 40) begin
      c++;
      @(negedge clk);
    end
    check("ignored_busy_cycles", 32'(c), 32'd5);
    check("ignored_hi", hi, 32'd0);
    check("ignored_lo", lo, 32'd42);
    m_hi = 32'd0; m_lo = 32'd42;

    run_op("op_none", 4'd0,  32'd9, 32'd9, 0, 32'd0, 32'd42);
    run_op("op_bad",  4'd15, 32'd9, 32'd9, 0, 32'd0, 32'd42);

    // back-to-back: second op launched the cycle busy is low
    run_op("b2b_mult", 4'd1, 32'd3, 32'd4, 5, 32'd0, 32'd12);
    run_op("b2b_divu", 4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    // HI=0, LO=0xFFFFFFFF, then the accumulate ops
    run_op("set_hi", 4'd5, 32'd0, 32'd0, 0, 32'd0, 32'd14);
    run_op("set_lo", 4'd6, 32'hFFFF_FFFF, 32'd0, 0, 32'd0, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op("maddu", 4'd8, 32'd1, 32'd1, 5, 32'd1, 32'd0);
    run_op("msub",  4'd9, 32'd2, 32'd3, 5, 32'd0, 32'hFFFF_FFFA);
`else
    run_op("maddu_off", 4'd8, 32'd1, 32'd1, 0, 32'd0, 32'hFFFF_FFFF);
    run_op("msub_off",  4'd9, 32'd2, 32'd3, 0, 32'd0, 32'hFFFF_FFFF);
`endif

    // reset during cycle 3 of a DIV aborts it with no commit
    start = 1'b1; op = 4'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    check("abort_busy_started", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (15) @(negedge clk);
    check("abort_late_busy", 32'(busy), 32'd0);
    check("abort_late_hi", hi, 32'd0);
    check("abort_late_lo", lo, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide unit with HI/LO registers for the EX stage of the pipelined MIPS core. It consumes the two operands read from the general register file (rs, rt) after forwarding and runs multi-cycle MULT/DIV with a busy counter. It holds the architectural HI and LO registers that MFHI/MFLO read. The hazard unit uses `busy` to stall MDU-dependent instructions in ID.

## Interface
- `MUL_CYCLES`, default 5: busy cycles for multiply-class ops, legal range ≥1.
- `DIV_CYCLES`, default 10: busy cycles for divide ops, legal range ≥1.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  op in EX this cycle; sampled on the rising edge.
- `op`  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; other codes behave as NONE.
- `a`  in  32  rs operand, forwarded.
- `b`  in  32  rt operand, forwarded.
- `busy`  out  1  multi-cycle op in flight.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.

## Operation
- State: `hi`, `lo`, a pending result `{phi, plo}`, a down-counter `cnt` sized for max(MUL_CYCLES, DIV_CYCLES), and an `op_is_div`/`div0` flag.
- Operations are accepted only when `start=1` and `busy=0`. The unit ignores `start` while `busy=1`; the hazard unit never issues in that case, and the bench checks that nothing changes.
- MULT: `{phi,plo}` = signed(a)×signed(b), 64-bit result. MULTU uses the unsigned product.
- DIV: `plo` = a/b signed, truncated toward zero. `phi` = a%b, with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (b=0, DIV or DIVU): the unit still runs DIV_CYCLES with `busy` high, and HI and LO are left unchanged at completion.
- MTHI writes `hi` ← a at the sampling edge. MTLO writes `lo` ← a at the sampling edge. Both are single-cycle, and `busy` stays 0.
- The result is computed at the start edge and latched into `{phi,plo}`. Operands are not needed after the start cycle.
- FSM states:
  - IDLE (cnt=0): a multiply-class start goes to RUN with cnt=MUL_CYCLES. A DIV/DIVU start goes to RUN with cnt=DIV_CYCLES.
  - RUN: cnt decrements each edge. On the edge where cnt goes 1→0, the unit commits `{hi,lo}` ← `{phi,plo}` (skipped if `div0`) and returns to IDLE.
- `busy` = (cnt≠0), driven directly from the register.
- `hi`/`lo` keep their old values throughout RUN.
- Reset, including mid-operation: cnt=0, `hi`=0, `lo`=0, pending result discarded, `busy`=0. An operation in flight is aborted with no commit.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0.
- Start sampled at edge k: `busy` is 1 after edge k through edge k+N−1, then 0 after edge k+N (N = MUL_CYCLES or DIV_CYCLES).
- New `hi`/`lo` are visible after edge k+N, the same cycle `busy` falls.
- Back-to-back: a start sampled at edge k+N, the cycle `busy` is low, is accepted. Zero dead cycles between ops.
- MTHI/MTLO at edge k: new value visible after edge k.
- `start` with `op`=NONE: no effect.
- `reset` and `start` at the same edge: reset wins.

## Configuration
- `MDU_MADD_EN` defined: ops 7–10 are implemented and take MUL_CYCLES. Each computes `{phi,plo}` = `{hi,lo}` ± a×b, using the HI/LO value at the start edge, with 64-bit wrap-around. MADD and MSUB use signed operands; MADDU and MSUBU use unsigned operands.
- `MDU_MADD_EN` undefined: codes 7–10 decode as NONE, with no state change and `busy` staying 0.

## Test plan
- Reset, then MULT with a=0xFFFFFFFF (−1) and b=2 → `busy` high for exactly 5 cycles, then hi=0xFFFFFFFF and lo=0xFFFFFFFE. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV with a=−7 (0xFFFFFFF9) and b=2 → 10 busy cycles, then lo=0xFFFFFFFD and hi=0xFFFFFFFF. DIVU with a=7, b=0 → 10 busy cycles, and hi/lo keep their previous values.
- MTHI a=0x12345678 followed by MTLO a=0x9ABCDEF0 on consecutive cycles → hi and lo update on consecutive edges, and `busy` never rises. A MULT issued during RUN is ignored, and the final result matches the first op only.
- Reset asserted at cycle 3 of a DIV → busy=0, hi=lo=0 the next cycle, and no later commit occurs.
- Back-to-back: MULT 3×4, then DIVU 100/7 started on the cycle `busy` falls → lo=12 after 5 cycles, then lo=14 and hi=2 after 10 more.
- With `MDU_MADD_EN`: hi=0 and lo=0xFFFFFFFF, then MADDU a=1, b=1 → hi=1, lo=0 after 5 cycles. Without the macro, the same op leaves hi and lo unchanged and `busy` stays 0.
